fp_mul_post: RTL and testbench

- Output stage directly downstream of the combinational single-precision multiplier (mult).
- Captures its {result, overflow, underflow} under a valid/ready handshake and applies IEEE-754 exception fix-up: overflow saturates to signed infinity, underflow flushes to signed zero.
- Buffers results in a small FIFO and keeps saturating exception counters for the host.

---
 rtl/fp_mul_pkg.sv | 18 +
 rtl/fp_fifo.sv | 67 ++++++
 rtl/fp_mul_post.sv | 90 +++++++++
 tb/tb_fp_mul_post.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the multiplier output stage.
//   FP_EXP_MAX : all-ones single-precision exponent (infinity / NaN)
//   FLAG_*     : bit positions inside the 3-bit result flag vector
//   fp_entry_t : one buffered result, fixed-up data plus its flags
package fp_mul_pkg;

    localparam logic [7:0] FP_EXP_MAX = 8'hFF;

    localparam int unsigned FLAG_OVF  = 0;
    localparam int unsigned FLAG_UNF  = 1;
    localparam int unsigned FLAG_ZERO = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  flags;
    } fp_entry_t;

endpackage

// File: rtl/fp_fifo.sv
// Generic synchronous FIFO of fp_entry_t with circular pointers and an
// occupancy counter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push, wr_entry : write request and entry (ignored when full)
//   pop            : read request (ignored when empty)
//   rd_entry       : entry at the head (raw storage, not masked)
//   full, empty    : occupancy status
module fp_fifo
    import fp_mul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  fp_entry_t wr_entry,
    input  logic      pop,
    output fp_entry_t rd_entry,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fp_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    // Storage needs no reset; empty masks stale contents downstream.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_mul_post.sv
// Output stage after the single-precision multiplier: applies exception
// fix-up (overflow -> signed infinity, underflow -> signed zero), buffers
// results in a FIFO and keeps saturating exception counters.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : input handshake
//   in_result/in_overflow/in_underflow : raw multiplier output
//   out_valid/out_ready           : output handshake
//   out_data/out_flags            : head result and flags {zero,unf,ovf}
//   clr_count                     : synchronous clear of both counters
//   ovf_count/unf_count           : saturating exception counters
module fp_mul_post
    import fp_mul_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [2:0]       out_flags,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] unf_count
);

    fp_entry_t fix_entry;
    fp_entry_t head_entry;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;

    // Overflow takes precedence so an illegal double flag yields infinity.
    always_comb begin
        fix_entry = '0;
        if (in_overflow) begin
            fix_entry.data            = {in_result[31], FP_EXP_MAX, 23'h0};
            fix_entry.flags[FLAG_OVF] = 1'b1;
        end else if (in_underflow) begin
            fix_entry.data            = {in_result[31], 31'h0};
            fix_entry.flags[FLAG_UNF] = 1'b1;
        end else begin
            fix_entry.data = in_result;
        end
        fix_entry.flags[FLAG_ZERO] = (fix_entry.data[30:0] == '0);
    end

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head_entry.data  : '0;
    assign out_flags = out_valid ? head_entry.flags : '0;

    fp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (fix_entry),
        .pop      (pop),
        .rd_entry (head_entry),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else if (push) begin
            if (fix_entry.flags[FLAG_OVF] && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
            if (fix_entry.flags[FLAG_UNF] && (unf_count != '1)) begin
                unf_count <= unf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_post.sv
// Directed self-checking bench for fp_mul_post (DEPTH=4, CNT_W=2 so that
// counter saturation is reachable in a few pushes).
module tb_fp_mul_post;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic             in_overflow;
    logic             in_underflow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [2:0]       out_flags;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;
    logic [CNT_W-1:0] unf_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fp_mul_post #(
        .DEPTH (4),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .clr_count    (clr_count),
        .ovf_count    (ovf_count),
        .unf_count    (unf_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic u);
        in_valid     = v;
        in_result    = r;
        in_overflow  = o;
        in_underflow = u;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b0;
        clr_count = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'h0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_ovf",       32'(ovf_count), 32'd0);
        check("rst_unf",       32'(unf_count), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        rst = 1'b0;

        // Plain result passes straight through with one cycle latency.
        out_ready = 1'b1;
        drive(1'b1, 32'h40C00000, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("plain_valid", 32'(out_valid), 32'd1);
        check("plain_data",  out_data, 32'h40C00000);
        check("plain_flags", 32'(out_flags), 32'd0);
        step();
        check("plain_drained_valid", 32'(out_valid), 32'd0);
        check("plain_drained_data",  out_data, 32'h0);

        // Overflow -> signed infinity.
        drive(1'b1, 32'hC1234567, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("ovf_data",  out_data, 32'hFF800000);
        check("ovf_flags", 32'(out_flags), 32'd1);
        check("ovf_count", 32'(ovf_count), 32'd1);
        step();

        // Underflow -> signed zero, zero flag also set.
        drive(1'b1, 32'h80000123, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("unf_data",  out_data, 32'h80000000);
        check("unf_flags", 32'(out_flags), 32'b110);
        check("unf_count", 32'(unf_count), 32'd1);
        check("unf_ovf_unchanged", 32'(ovf_count), 32'd1);
        step();

        // Genuine zero input: only the zero flag.
        drive(1'b1, 32'h80000000, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("zero_flags", 32'(out_flags), 32'b100);
        step();

        // Fill with consumer stalled: 5 offered, 4 accepted.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b0);
            check($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("full_in_ready",  32'(in_ready), 32'd0);
        check("full_head_data", out_data, 32'h3F800000);
        step();
        check("stall_head_stable", out_data, 32'h3F800000);

        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("drain_data_%0d", i), out_data, 32'h3F800000 + 32'(i));
            check($sformatf("drain_in_ready_%0d", i), 32'(in_ready), 32'd1);
        end
        step();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Streaming through pointer wrap-around.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'hA0000000 + 32'(k), 1'b0, 1'b0);
            step();
            check($sformatf("wrap_data_%0d", k), out_data, 32'hA0000000 + 32'(k));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("wrap_empty", 32'(out_valid), 32'd0);

        // Overflow counter saturates at 3 (starting from 1).
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h7F000000, 1'b1, 1'b0);
            step();
            check($sformatf("sat_ovf_%0d", k), 32'(ovf_count), (k == 0) ? 32'd2 : 32'd3);
            check($sformatf("sat_data_%0d", k), out_data, 32'h7F800000);
        end

        // Clear wins over a simultaneous increment.
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("clr_ovf", 32'(ovf_count), 32'd0);
        check("clr_unf", 32'(unf_count), 32'd0);
        step();

        // Both flags: overflow wins, only ovf counted.
        drive(1'b1, 32'h00000001, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("both_data",  out_data, 32'h7F800000);
        check("both_flags", 32'(out_flags), 32'd1);
        check("both_ovf",   32'(ovf_count), 32'd1);
        check("both_unf",   32'(unf_count), 32'd0);
        step();

        // Mid-stream reset drops buffered entries; handshake in reset ignored.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h11111111 * 32'(k + 1), 1'b0, 1'b1);
            step();
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  out_data, 32'h0);
        check("mid_rst_ovf",   32'(ovf_count), 32'd0);
        check("mid_rst_unf",   32'(unf_count), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h12345678, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("post_rst_data", out_data, 32'h12345678);
        step();
        check("post_rst_alone", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
